// File: rtl/lct_ghost_fifo_pkg.sv
// LCT word layout, record types and key helpers
// shared by the ghost filter and its output FIFO.
package lct_ghost_fifo_pkg;

  localparam int BXN_W      = 12;
  localparam int KEY_W      = 7;
  localparam int Q_W        = 2;
  localparam int WORD_W     = BXN_W + 2 + Q_W + KEY_W;
  localparam int BX_MAX_DEF = 3563;

  typedef struct packed {
    logic             v;
    logic [KEY_W-1:0] key;
    logic [Q_W-1:0]   q;
  } lct_rec_t;

  typedef struct packed {
    lct_rec_t h;
    lct_rec_t l;
  } hist_t;

  function automatic logic key_adj(
    input logic [KEY_W-1:0] a,
    input logic [KEY_W-1:0] b
  );
    logic [KEY_W-1:0] d;
    d = (a >= b) ? (a - b) : (b - a);
    return d <= KEY_W'(1);
  endfunction

  // A valid past record of equal or better quality hides the candidate.
  function automatic logic rec_hit(
    input lct_rec_t         r,
    input logic [KEY_W-1:0] key,
    input logic [Q_W-1:0]   q
  );
    return r.v && key_adj(r.key, key) && (r.q >= q);
  endfunction

  function automatic logic [WORD_W-1:0] make_word(
    input logic [BXN_W-1:0] bxn,
    input logic             sec,
    input logic             fa,
    input logic [Q_W-1:0]   q,
    input logic [KEY_W-1:0] key
  );
    return {bxn, sec, fa, q, key};
  endfunction

endpackage

// File: rtl/lct_fifo2w.sv
// Dual-write, single-read first-word-fall-through FIFO
// with occupancy count and drop reporting.
module lct_fifo2w
  import lct_ghost_fifo_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = WORD_W,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_wr0_v,
  input  logic [W-1:0]  i_wr0_d,
  input  logic          i_wr1_v,
  input  logic [W-1:0]  i_wr1_d,
  input  logic          i_rd_en,
  output logic [W-1:0]  o_rd_data,
  output logic          o_rd_valid,
  output logic [CW-1:0] o_count,
  output logic          o_drop
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [CW-1:0] r_cnt;

  logic [CW-1:0] w_space;
  logic [1:0]    w_nreq;
  logic [1:0]    w_nwr;
  logic [W-1:0]  w_d0;
  logic          w_pop;
  logic [AW-1:0] w_wp1;

  assign w_space = CW'(DEPTH) - r_cnt;
  assign w_nreq  = {1'b0, i_wr0_v} + {1'b0, i_wr1_v};
  assign w_d0    = i_wr0_v ? i_wr0_d : i_wr1_d;
  assign w_pop   = i_rd_en && (r_cnt != '0);
  assign w_wp1   = r_wp + AW'(1);

  // Room is judged before the pop; the first word always wins.
  always_comb begin
    w_nwr = w_nreq;
    if (w_space < CW'(w_nreq))
      w_nwr = w_space[1:0];
  end

  assign o_drop = (w_nwr != w_nreq);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
    end else begin
      if (w_nwr != 2'd0)
        r_mem[r_wp] <= w_d0;
      if (w_nwr == 2'd2)
        r_mem[w_wp1] <= i_wr1_d;
      r_wp  <= r_wp + AW'(w_nwr);
      r_rp  <= r_rp + AW'(w_pop);
      r_cnt <= r_cnt + CW'(w_nwr) - CW'(w_pop);
    end
  end

  assign o_rd_data  = r_mem[r_rp];
  assign o_rd_valid = (r_cnt != '0);
  assign o_count    = r_cnt;

endmodule

// File: rtl/lct_ghost_fifo.sv
// BX stamping, ghost suppression against recent accepted LCTs,
// and queueing of survivors for readout.
module lct_ghost_fifo
  import lct_ghost_fifo_pkg::*;
#(
  parameter int DEAD_BX = 2,
  parameter int DEPTH   = 8,
  parameter int BX_MAX  = BX_MAX_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                hv,
  input  logic [Q_W-1:0]      hp,
  input  logic [KEY_W-1:0]    hnp,
  input  logic                hfap,
  input  logic                lv,
  input  logic [Q_W-1:0]      lp,
  input  logic [KEY_W-1:0]    lnp,
  input  logic                lfap,
  input  logic                bxn_rst,
  input  logic                trig_stop,
  input  logic                rd_en,
  output logic [WORD_W-1:0]   rd_data,
  output logic                rd_valid,
  output logic [3:0]          fifo_count,
  output logic                overflow,
  output logic [7:0]          ghost_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [BXN_W-1:0] r_bxn;
  logic [BXN_W-1:0] r_a_bxn;
  lct_rec_t         r_a_h;
  lct_rec_t         r_a_l;
  logic             r_a_hfa;
  logic             r_a_lfa;
  hist_t            r_hist [DEAD_BX];
  logic [7:0]       r_ghost;
  logic             r_ovf;

  logic              w_h_hist;
  logic              w_l_hist;
  logic              w_h_ghost;
  logic              w_l_ghost;
  logic              w_h_acc;
  logic              w_l_acc;
  logic [8:0]        w_gsum;
  logic [WORD_W-1:0] w_h_word;
  logic [WORD_W-1:0] w_l_word;
  logic [CW-1:0]     w_cnt;
  logic              w_drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_bxn <= '0;
    else if (bxn_rst || r_bxn == BXN_W'(BX_MAX))
      r_bxn <= '0;
    else
      r_bxn <= r_bxn + BXN_W'(1);
  end

  // Stage A: capture both LCTs with the BX they arrived in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_bxn <= '0;
      r_a_h   <= '0;
      r_a_l   <= '0;
      r_a_hfa <= 1'b0;
      r_a_lfa <= 1'b0;
    end else begin
      r_a_bxn   <= r_bxn;
      r_a_h.v   <= hv & ~trig_stop;
      r_a_h.key <= hnp;
      r_a_h.q   <= hp;
      r_a_hfa   <= hfap;
      r_a_l.v   <= lv & ~trig_stop;
      r_a_l.key <= lnp;
      r_a_l.q   <= lp;
      r_a_lfa   <= lfap;
    end
  end

  always_comb begin
    w_h_hist = 1'b0;
    w_l_hist = 1'b0;
    for (int i = 0; i < DEAD_BX; i++) begin
      w_h_hist |= rec_hit(r_hist[i].h, r_a_h.key, r_a_h.q)
                | rec_hit(r_hist[i].l, r_a_h.key, r_a_h.q);
      w_l_hist |= rec_hit(r_hist[i].h, r_a_l.key, r_a_l.q)
                | rec_hit(r_hist[i].l, r_a_l.key, r_a_l.q);
    end
  end

  assign w_h_ghost = r_a_h.v & w_h_hist;
  assign w_h_acc   = r_a_h.v & ~w_h_hist;
  assign w_l_ghost = r_a_l.v
                   & (w_l_hist
                   | (w_h_acc & key_adj(r_a_l.key, r_a_h.key)));
  assign w_l_acc   = r_a_l.v & ~w_l_ghost;

  // History holds accepted LCTs, including ones the FIFO dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEAD_BX; i++)
        r_hist[i] <= '0;
    end else begin
      r_hist[0].h.v   <= w_h_acc;
      r_hist[0].h.key <= r_a_h.key;
      r_hist[0].h.q   <= r_a_h.q;
      r_hist[0].l.v   <= w_l_acc;
      r_hist[0].l.key <= r_a_l.key;
      r_hist[0].l.q   <= r_a_l.q;
      for (int i = 1; i < DEAD_BX; i++)
        r_hist[i] <= r_hist[i-1];
    end
  end

  assign w_gsum = {1'b0, r_ghost} + 9'(w_h_ghost) + 9'(w_l_ghost);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ghost <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_ghost <= w_gsum[8] ? 8'hFF : w_gsum[7:0];
      r_ovf   <= r_ovf | w_drop;
    end
  end

  assign w_h_word = make_word(r_a_bxn, 1'b0, r_a_hfa,
                              r_a_h.q, r_a_h.key);
  assign w_l_word = make_word(r_a_bxn, 1'b1, r_a_lfa,
                              r_a_l.q, r_a_l.key);

  lct_fifo2w #(
    .DEPTH (DEPTH),
    .W     (WORD_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_wr0_v    (w_h_acc),
    .i_wr0_d    (w_h_word),
    .i_wr1_v    (w_l_acc),
    .i_wr1_d    (w_l_word),
    .i_rd_en    (rd_en),
    .o_rd_data  (rd_data),
    .o_rd_valid (rd_valid),
    .o_count    (w_cnt),
    .o_drop     (w_drop)
  );

  assign fifo_count = 4'(w_cnt);
  assign overflow   = r_ovf;
  assign ghost_cnt  = r_ghost;

endmodule

// File: tb/tb_lct_ghost_fifo.sv
// Scoreboard bench for lct_ghost_fifo: expected words queued
// at stimulus time and compared as they are read out.
module tb_lct_ghost_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        hv, hfap, lv, lfap;
  logic [1:0]  hp, lp;
  logic [6:0]  hnp, lnp;
  logic        bxn_rst, trig_stop, rd_en;
  logic [22:0] rd_data;
  logic        rd_valid;
  logic [3:0]  fifo_count;
  logic        overflow;
  logic [7:0]  ghost_cnt;

  logic [22:0] q[$];
  logic [22:0] exp_w;
  logic [11:0] m_bx;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          g_exp = 0;

  lct_ghost_fifo #(.DEAD_BX(2), .DEPTH(8), .BX_MAX(3563)) dut (
    .clk(clk), .rst(rst),
    .hv(hv), .hp(hp), .hnp(hnp), .hfap(hfap),
    .lv(lv), .lp(lp), .lnp(lnp), .lfap(lfap),
    .bxn_rst(bxn_rst), .trig_stop(trig_stop), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .fifo_count(fifo_count), .overflow(overflow),
    .ghost_cnt(ghost_cnt)
  );

  always #5 clk = ~clk;

  // Reference BX counter
  always @(posedge clk or posedge rst) begin
    if (rst) m_bx <= '0;
    else if (bxn_rst || m_bx == 12'd3563) m_bx <= '0;
    else m_bx <= m_bx + 12'd1;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      hv = 0; lv = 0; rd_en = 0;
    end
  endtask

  task automatic lct(input logic h, input logic [1:0] hq,
                     input logic [6:0] hk, input logic l,
                     input logic [1:0] lq, input logic [6:0] lk,
                     input logic eh, input logic el);
    @(negedge clk);
    rd_en = 0;
    hv = h; hp = hq; hnp = hk; hfap = hk[0];
    lv = l; lp = lq; lnp = lk; lfap = lk[0];
    if (eh) q.push_back({m_bx, 1'b0, hk[0], hq, hk});
    if (el) q.push_back({m_bx, 1'b1, lk[0], lq, lk});
  endtask

  task automatic drain;
    int idle_n = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      hv = 0; lv = 0; rd_en = 0;
      if (rd_valid) begin
        idle_n = 0;
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL drain_extra got=%h want=none", rd_data);
        end else begin
          exp_w = q.pop_front();
          if (rd_data !== exp_w) begin
            n_bad++;
            $display("FAIL drain_word got=%h want=%h", rd_data, exp_w);
          end
        end
        rd_en = 1;
      end else begin
        idle_n++;
        if (idle_n >= 3) break;
      end
    end
    rd_en = 0;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain_left got=%0d want=0", q.size());
      q.delete();
    end
  endtask

  task automatic test_reset;
    rst = 1; hv = 0; lv = 0; hp = 0; lp = 0; hnp = 0; lnp = 0;
    hfap = 0; lfap = 0; bxn_rst = 0; trig_stop = 0; rd_en = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp += 5;
    if (rd_valid !== 1'b0) begin n_bad++;
      $display("FAIL rst_valid got=%b want=0", rd_valid); end
    if (fifo_count !== 4'd0) begin n_bad++;
      $display("FAIL rst_count got=%0d want=0", fifo_count); end
    if (overflow !== 1'b0) begin n_bad++;
      $display("FAIL rst_ovf got=%b want=0", overflow); end
    if (ghost_cnt !== 8'd0) begin n_bad++;
      $display("FAIL rst_ghost got=%0d want=0", ghost_cnt); end
    if (rd_data !== 23'd0) begin n_bad++;
      $display("FAIL rst_data got=%h want=0", rd_data); end
    rst = 0;
  endtask

  task automatic test_latency;
    for (int i = 0; i < 20; i++) begin
      if (m_bx == 12'd4) break;
      @(negedge clk);
    end
    lct(1, 2'd3, 7'd40, 0, 2'd0, 7'd0, 1, 0);
    idle(1);
    n_cmp++;
    if (rd_valid !== 1'b0) begin n_bad++;
      $display("FAIL lat_early got=%b want=0", rd_valid); end
    @(negedge clk);
    n_cmp += 3;
    if (rd_valid !== 1'b1) begin n_bad++;
      $display("FAIL lat_valid got=%b want=1", rd_valid); end
    if (rd_data !== {12'd5, 1'b0, 1'b0, 2'd3, 7'd40}) begin n_bad++;
      $display("FAIL lat_data got=%h want=%h", rd_data,
               {12'd5, 1'b0, 1'b0, 2'd3, 7'd40}); end
    if (fifo_count !== 4'd1) begin n_bad++;
      $display("FAIL lat_count got=%0d want=1", fifo_count); end
    drain();
  endtask

  task automatic test_ghost_window;
    lct(1, 2'd2, 7'd40, 0, 2'd0, 7'd0, 1, 0);
    lct(1, 2'd2, 7'd41, 0, 2'd0, 7'd0, 0, 0);
    g_exp++;
    lct(1, 2'd3, 7'd39, 0, 2'd0, 7'd0, 1, 0);
    drain();
    n_cmp++;
    if (ghost_cnt !== 8'(g_exp)) begin n_bad++;
      $display("FAIL ghost_adj got=%0d want=%0d", ghost_cnt, g_exp); end
  endtask

  task automatic test_same_bx;
    lct(1, 2'd2, 7'd20, 1, 2'd1, 7'd21, 1, 0);
    g_exp++;
    idle(3);
    lct(1, 2'd2, 7'd20, 1, 2'd1, 7'd60, 1, 1);
    drain();
    n_cmp++;
    if (ghost_cnt !== 8'(g_exp)) begin n_bad++;
      $display("FAIL ghost_pair got=%0d want=%0d", ghost_cnt, g_exp); end
  endtask

  task automatic test_dead_window;
    lct(1, 2'd1, 7'd10, 0, 2'd0, 7'd0, 1, 0);
    idle(2);
    lct(1, 2'd1, 7'd10, 0, 2'd0, 7'd0, 1, 0);
    drain();
    lct(1, 2'd1, 7'd10, 0, 2'd0, 7'd0, 1, 0);
    idle(1);
    lct(1, 2'd1, 7'd10, 0, 2'd0, 7'd0, 0, 0);
    g_exp++;
    drain();
    n_cmp++;
    if (ghost_cnt !== 8'(g_exp)) begin n_bad++;
      $display("FAIL ghost_dead got=%0d want=%0d", ghost_cnt, g_exp); end
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 7; i++)
      lct(1, 2'd1, 7'(i * 3), 0, 2'd0, 7'd0, 1, 0);
    lct(1, 2'd2, 7'd50, 1, 2'd2, 7'd70, 1, 0);
    @(negedge clk);
    hv = 0; lv = 0;
    n_cmp += 3;
    if (fifo_count !== 4'd7) begin n_bad++;
      $display("FAIL ovf_fill got=%0d want=7", fifo_count); end
    if (overflow !== 1'b0) begin n_bad++;
      $display("FAIL ovf_early got=%b want=0", overflow); end
    exp_w = q.pop_front();
    if (rd_data !== exp_w) begin n_bad++;
      $display("FAIL ovf_head got=%h want=%h", rd_data, exp_w); end
    rd_en = 1;
    @(negedge clk);
    rd_en = 0;
    n_cmp += 2;
    if (fifo_count !== 4'd7) begin n_bad++;
      $display("FAIL ovf_count got=%0d want=7", fifo_count); end
    if (overflow !== 1'b1) begin n_bad++;
      $display("FAIL ovf_flag got=%b want=1", overflow); end
    drain();
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 4000; i++) begin
      if (m_bx == 12'd3562) break;
      @(negedge clk);
    end
    n_cmp++;
    if (m_bx != 12'd3562) begin n_bad++;
      $display("FAIL wrap_wait got=%0d want=3562", m_bx); end
    lct(1, 2'd1, 7'd30, 0, 2'd0, 7'd0, 0, 0);
    q.push_back({12'd3563, 1'b0, 1'b0, 2'd1, 7'd30});
    lct(1, 2'd1, 7'd90, 0, 2'd0, 7'd0, 0, 0);
    q.push_back({12'd0, 1'b0, 1'b0, 2'd1, 7'd90});
    drain();
  endtask

  task automatic test_bxn_rst;
    @(negedge clk);
    bxn_rst = 1;
    lct(1, 2'd2, 7'd71, 0, 2'd0, 7'd0, 0, 0);
    bxn_rst = 0;
    q.push_back({12'd0, 1'b0, 1'b1, 2'd2, 7'd71});
    drain();
  endtask

  task automatic test_trig_stop;
    @(negedge clk);
    trig_stop = 1;
    hv = 1; hp = 2'd1; hnp = 7'd100; hfap = 0;
    lv = 1; lp = 2'd1; lnp = 7'd110; lfap = 0;
    idle(1);
    trig_stop = 0;
    idle(2);
    n_cmp += 3;
    if (rd_valid !== 1'b0) begin n_bad++;
      $display("FAIL stop_valid got=%b want=0", rd_valid); end
    if (fifo_count !== 4'd0) begin n_bad++;
      $display("FAIL stop_count got=%0d want=0", fifo_count); end
    if (ghost_cnt !== 8'(g_exp)) begin n_bad++;
      $display("FAIL stop_ghost got=%0d want=%0d", ghost_cnt, g_exp); end
    lct(1, 2'd1, 7'd100, 0, 2'd0, 7'd0, 1, 0);
    drain();
  endtask

  task automatic test_rst_mid;
    lct(1, 2'd1, 7'd5, 0, 2'd0, 7'd0, 0, 0);
    lct(1, 2'd1, 7'd50, 0, 2'd0, 7'd0, 0, 0);
    idle(2);
    n_cmp++;
    if (fifo_count !== 4'd2) begin n_bad++;
      $display("FAIL mid_pre got=%0d want=2", fifo_count); end
    #2 rst = 1;
    #1;
    n_cmp += 4;
    if (rd_valid !== 1'b0) begin n_bad++;
      $display("FAIL mid_valid got=%b want=0", rd_valid); end
    if (fifo_count !== 4'd0) begin n_bad++;
      $display("FAIL mid_count got=%0d want=0", fifo_count); end
    if (overflow !== 1'b0) begin n_bad++;
      $display("FAIL mid_ovf got=%b want=0", overflow); end
    if (ghost_cnt !== 8'd0) begin n_bad++;
      $display("FAIL mid_ghost got=%0d want=0", ghost_cnt); end
    q.delete();
    g_exp = 0;
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_ghost_window();
    test_same_bx();
    test_dead_window();
    test_overflow();
    test_wrap();
    test_bxn_rst();
    test_trig_stop();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
